down_counter_sequencer: RTL

//   Control FSM for a loadable synchronous down counter datapath.

---
 rtl/down_counter_sequencer.sv | 98 +++++++++
 1 files changed

// File: rtl/down_counter_sequencer.sv
// Load/run/pause/abort sequencer for a loadable down counter.
// Optional macro DOWN_COUNTER_AUTO_RELOAD_EN: periodic reload instead of DONE.
module down_counter_sequencer #(
    parameter int WIDTH = 3
) (
    input  logic             CLK,
    input  logic             not_RST,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             pause,
    input  logic             abort,
    input  logic             ack,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t state;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload;
`endif

    always_ff @(posedge CLK) begin
        if (!not_RST) begin
            state <= IDLE;
            count <= ZERO;
            tc    <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload <= ZERO;
`endif
        end else begin
            tc <= 1'b0;
            // abort wins over every state action, but IDLE ignores it
            if (abort && (state != IDLE)) begin
                state <= IDLE;
                count <= ZERO;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                            reload <= load_val;
`endif
                            if (load_val == ZERO) begin
                                count <= ZERO;
                                tc    <= 1'b1;
                                state <= DONE;
                            end else begin
                                count <= load_val;
                                state <= COUNT;
                            end
                        end
                    end
                    COUNT: begin
                        if (!pause) begin
                            if (count > ONE) begin
                                count <= count - ONE;
                            end else begin
                                tc <= 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                                count <= reload;
`else
                                count <= ZERO;
                                state <= DONE;
`endif
                            end
                        end
                    end
                    DONE: begin
                        count <= ZERO;
                        if (ack) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        count <= ZERO;
                    end
                endcase
            end
        end
    end

    assign busy = (state == COUNT);
    assign done = (state == DONE);

endmodule
